log_lane_ctrl: RTL and testbench

Per-frame motion controller for the log sprite layer: owns the origin (x, y) and control nibble of all 20 log sprites and advances them once per video frame according to per-lane speed, direction and period settings. Sits between the processor register bus and the log sprite pixel source. Its double-buffered outputs drive the sprite source's origin and ctrl inputs directly, so they only change between frames.

---
 rtl/log_lane_ctrl_if.sv | 10 +
 rtl/log_lane_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_log_lane_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/log_lane_ctrl_if.sv
// Processor register-write bus into the log lane controller.
// The CPU side drives the strobe, address and data; the controller only listens.
interface log_lane_ctrl_if;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/log_lane_ctrl.sv
// Per-frame motion controller for the log sprite layer.
// Holds a working copy of every log's x/ctrl that the CPU and the per-frame
// mover update, and a shadow copy that drives the sprite source. The shadow
// copy only changes in COMMIT, so the sprite source never sees a half-moved frame.
module log_lane_ctrl #(
    parameter int N_LOGS     = 20,
    parameter int N_LANES    = 4,
    parameter int H_MAX      = 640,
    parameter int LANE_Y0    = 96,
    parameter int LANE_PITCH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_tick,
    log_lane_ctrl_if.slave        bus,
    output logic [N_LOGS*11-1:0]  log_x,
    output logic [N_LOGS*11-1:0]  log_y,
    output logic [N_LOGS*4-1:0]   log_ctrl,
    output logic                  busy,
    output logic                  overrun
);
    localparam int PER_LANE = N_LOGS / N_LANES;
    localparam int IW       = $clog2(N_LOGS);
    localparam int LW       = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int ADDR_LANE0 = 32;
    localparam int ADDR_CLR   = 63;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_COMMIT} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;

    logic [10:0]     work_x_reg    [N_LOGS];
    logic [3:0]      work_ctrl_reg [N_LOGS];
    logic [10:0]     shad_x_reg    [N_LOGS];
    logic [3:0]      shad_ctrl_reg [N_LOGS];

    logic            pend_en_reg   [N_LANES];
    logic            pend_dir_reg  [N_LANES];
    logic [3:0]      pend_per_reg  [N_LANES];
    logic [3:0]      pend_step_reg [N_LANES];
    logic            act_en_reg    [N_LANES];
    logic            act_dir_reg   [N_LANES];
    logic [3:0]      act_per_reg   [N_LANES];
    logic [3:0]      act_step_reg  [N_LANES];
    logic [3:0]      fcnt_reg      [N_LANES];

    logic            overrun_reg;

    // Decoded CPU write fields; x is clamped so working x always stays below H_MAX.
    logic [10:0]     wr_x;
    logic [3:0]      wr_ctrl;
    logic            unused_wr_bit;
    assign wr_x    = (bus.wr_data[10:0] >= 11'(H_MAX)) ? 11'(H_MAX - 1) : bus.wr_data[10:0];
    assign wr_ctrl = bus.wr_data[14:11];
    assign unused_wr_bit = bus.wr_data[15];

    // Shared mover: one log per UPDATE cycle, selected by idx_reg.
    logic [LW-1:0]   cur_lane;
    logic [11:0]     cur_x, cur_step, sum_x, right_x, left_x;
    logic [10:0]     moved_x;
    logic            lane_move;
    assign cur_lane  = LW'(idx_reg / IW'(PER_LANE));
    assign cur_x     = {1'b0, work_x_reg[idx_reg]};
    assign cur_step  = {8'd0, act_step_reg[cur_lane]};
    assign sum_x     = cur_x + cur_step;
    assign right_x   = (sum_x >= 12'(H_MAX)) ? sum_x - 12'(H_MAX) : sum_x;
    assign left_x    = (cur_x < cur_step) ? cur_x + 12'(H_MAX) - cur_step : cur_x - cur_step;
    assign moved_x   = act_dir_reg[cur_lane] ? left_x[10:0] : right_x[10:0];
    assign lane_move = act_en_reg[cur_lane] && (fcnt_reg[cur_lane] == act_per_reg[cur_lane]);

    // State and log index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Frame sequencing: IDLE -> UPDATE (one log per cycle) -> COMMIT -> IDLE.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (frame_tick) begin
                    state_next = S_UPDATE;
                    idx_next   = '0;
                end
            end
            S_UPDATE: begin
                if (idx_reg == IW'(N_LOGS - 1)) begin
                    state_next = S_COMMIT;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign busy = (state_reg != S_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < N_LOGS; gi++) begin : g_log
            // Working copy: a CPU write wins over the move of the same log in the same cycle.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    work_x_reg[gi]    <= '0;
                    work_ctrl_reg[gi] <= '0;
                end else if (bus.wr_en && bus.wr_addr == 6'(gi)) begin
                    work_x_reg[gi]    <= wr_x;
                    work_ctrl_reg[gi] <= wr_ctrl;
                end else if (state_reg == S_UPDATE && idx_reg == IW'(gi) && lane_move) begin
                    work_x_reg[gi]    <= moved_x;
                end
            end

            // Shadow copy: snapshot of the working copy taken once per frame.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    shad_x_reg[gi]    <= '0;
                    shad_ctrl_reg[gi] <= '0;
                end else if (state_reg == S_COMMIT) begin
                    shad_x_reg[gi]    <= work_x_reg[gi];
                    shad_ctrl_reg[gi] <= work_ctrl_reg[gi];
                end
            end

            assign log_x[11*gi +: 11]  = shad_x_reg[gi];
            assign log_ctrl[4*gi +: 4] = shad_ctrl_reg[gi];
            assign log_y[11*gi +: 11]  = 11'(LANE_Y0 + (gi / PER_LANE) * LANE_PITCH);
        end

        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            // Pending cfg from the CPU; becomes active only at a frame start.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pend_en_reg[gi]   <= 1'b0;
                    pend_dir_reg[gi]  <= 1'b0;
                    pend_per_reg[gi]  <= '0;
                    pend_step_reg[gi] <= '0;
                end else if (bus.wr_en && bus.wr_addr == 6'(ADDR_LANE0 + gi)) begin
                    pend_en_reg[gi]   <= bus.wr_data[0];
                    pend_dir_reg[gi]  <= bus.wr_data[1];
                    pend_per_reg[gi]  <= bus.wr_data[5:2];
                    pend_step_reg[gi] <= bus.wr_data[9:6];
                end
            end

            // Active cfg is frozen for the whole frame.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    act_en_reg[gi]   <= 1'b0;
                    act_dir_reg[gi]  <= 1'b0;
                    act_per_reg[gi]  <= '0;
                    act_step_reg[gi] <= '0;
                end else if (state_reg == S_IDLE && frame_tick) begin
                    act_en_reg[gi]   <= pend_en_reg[gi];
                    act_dir_reg[gi]  <= pend_dir_reg[gi];
                    act_per_reg[gi]  <= pend_per_reg[gi];
                    act_step_reg[gi] <= pend_step_reg[gi];
                end
            end

            // Frame counter: a lane moves on frames where fcnt matches its period.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    fcnt_reg[gi] <= '0;
                end else if (state_reg == S_COMMIT) begin
                    if (!act_en_reg[gi] || fcnt_reg[gi] == act_per_reg[gi]) begin
                        fcnt_reg[gi] <= '0;
                    end else begin
                        fcnt_reg[gi] <= fcnt_reg[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Sticky overrun; a new overrun event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_reg <= 1'b0;
        end else if (frame_tick && state_reg != S_IDLE) begin
            overrun_reg <= 1'b1;
        end else if (bus.wr_en && bus.wr_addr == 6'(ADDR_CLR)) begin
            overrun_reg <= 1'b0;
        end
    end

    assign overrun = overrun_reg;
endmodule

// File: tb/tb_log_lane_ctrl.sv
// Self-checking bench for log_lane_ctrl: table-driven register writes,
// hand-written wrap/period/collision/overrun/reset sequences, and random
// frames checked against a frame-level reference model.
module tb_log_lane_ctrl;
    localparam int NL = 20;
    localparam int HM = 640;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_tick = 1'b0;
    log_lane_ctrl_if bus();
    logic [NL*11-1:0] log_x, log_y;
    logic [NL*4-1:0]  log_ctrl;
    logic busy, overrun;

    always #5 clk = ~clk;

    log_lane_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .bus(bus),
        .log_x(log_x), .log_y(log_y), .log_ctrl(log_ctrl),
        .busy(busy), .overrun(overrun)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state (plain integers).
    int wx[NL], wc[NL], sx[NL], sc[NL];
    int p_en[4], p_dir[4], p_per[4], p_step[4];
    int a_en[4], a_dir[4], a_per[4], a_step[4], fcnt[4];
    int m_ovr;
    int frame_no = 0;

    typedef struct { int addr; int data; int chk; int ex; int ec; } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_x(input int i);
        return int'(log_x[11*i +: 11]);
    endfunction
    function automatic int dut_c(input int i);
        return int'(log_ctrl[4*i +: 4]);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NL; i++) begin wx[i] = 0; wc[i] = 0; sx[i] = 0; sc[i] = 0; end
        for (int k = 0; k < 4; k++) begin
            p_en[k] = 0; p_dir[k] = 0; p_per[k] = 0; p_step[k] = 0;
            a_en[k] = 0; a_dir[k] = 0; a_per[k] = 0; a_step[k] = 0; fcnt[k] = 0;
        end
        m_ovr = 0;
    endfunction

    function automatic void m_write(input int a, input int d, input bit tick_now);
        if (a < NL) begin
            wx[a] = ((d & 2047) >= HM) ? HM - 1 : (d & 2047);
            wc[a] = (d >> 11) & 15;
        end else if (a >= 32 && a < 36) begin
            p_en[a-32] = d & 1;  p_dir[a-32] = (d >> 1) & 1;
            p_per[a-32] = (d >> 2) & 15;  p_step[a-32] = (d >> 6) & 15;
        end else if (a == 63 && !tick_now) begin
            m_ovr = 0;
        end
    endfunction

    function automatic bit m_moves(input int k);
        return a_en[k] == 1 && fcnt[k] == a_per[k];
    endfunction

    function automatic int m_moved(input int x, input int k);
        if (a_dir[k] == 1) return (x - a_step[k] + HM) % HM;
        return (x + a_step[k]) % HM;
    endfunction

    function automatic void m_commit();
        for (int i = 0; i < NL; i++) begin sx[i] = wx[i]; sc[i] = wc[i]; end
        for (int k = 0; k < 4; k++)
            fcnt[k] = (a_en[k] == 0 || fcnt[k] == a_per[k]) ? 0 : fcnt[k] + 1;
    endfunction

    function automatic int lane_word(input int en, input int dir, input int per, input int step);
        return en | (dir << 1) | (per << 2) | (step << 6);
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < NL; i++) begin
            check($sformatf("%s x[%0d]", tag, i), dut_x(i), sx[i]);
            check($sformatf("%s ctrl[%0d]", tag, i), dut_c(i), sc[i]);
        end
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " overrun"}, int'(overrun), m_ovr);
    endtask

    // Single register write while idle; starts and ends at posedge+1.
    task automatic do_write(input int a, input int d);
        bus.wr_en = 1'b1; bus.wr_addr = 6'(a); bus.wr_data = 16'(d);
        @(posedge clk);
        m_write(a, d, 1'b0);
        #1 bus.wr_en = 1'b0;
        $display("write addr=%0d data=0x%04h", a, d);
    endtask

    // One full frame; optional write and/or extra tick at edge E1..E21 (0 = none).
    task automatic run_frame(input int wr_edge, input int waddr, input int wdata, input int tick_edge);
        frame_tick = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            a_en[k] = p_en[k]; a_dir[k] = p_dir[k]; a_per[k] = p_per[k]; a_step[k] = p_step[k];
        end
        #1 frame_tick = 1'b0;
        check("busy_after_E0", int'(busy), 1);
        for (int e = 1; e <= 21; e++) begin
            bit wr_now, tk_now;
            int lg;
            wr_now = (e == wr_edge);
            tk_now = (e == tick_edge);
            if (wr_now) begin
                bus.wr_en = 1'b1; bus.wr_addr = 6'(waddr); bus.wr_data = 16'(wdata);
            end
            frame_tick = tk_now;
            @(posedge clk);
            if (e <= NL) begin
                lg = e - 1;
                if (!(wr_now && waddr == lg) && m_moves(lg / 5))
                    wx[lg] = m_moved(wx[lg], lg / 5);
            end else begin
                m_commit();
            end
            if (wr_now) m_write(waddr, wdata, tk_now);
            if (tk_now) m_ovr = 1;
            #1 bus.wr_en = 1'b0; frame_tick = 1'b0;
            if (e == 20) check("busy_in_commit", int'(busy), 1);
        end
        frame_no++;
        $display("frame %0d committed (wr_edge=%0d addr=%0d tick_edge=%0d)", frame_no, wr_edge, waddr, tick_edge);
        check_all($sformatf("frame%0d", frame_no));
    endtask

    initial begin
        int pv[6];
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        m_reset();

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check_all("reset");
        for (int i = 0; i < NL; i++)
            check($sformatf("log_y[%0d]", i), int'(log_y[11*i +: 11]), 96 + 32 * (i / 5));

        // Table-driven register writes, each committed by one frame with lanes idle.
        vecs[0] = '{0,  (5 << 11) | 639,           0,  639, 5};
        vecs[1] = '{1,  (15 << 11) | 640,          1,  639, 15};
        vecs[2] = '{2,  32768 | (3 << 11) | 2047,  2,  639, 3};
        vecs[3] = '{19, (9 << 11),                 19, 0,   9};
        vecs[4] = '{20, (7 << 11) | 77,            0,  639, 5};
        vecs[5] = '{48, 65535,                     19, 0,   9};
        vecs[6] = '{10, 638,                       10, 638, 0};
        for (int v = 0; v < 7; v++) begin
            do_write(vecs[v].addr, vecs[v].data);
            if (v == 0) check("x_before_commit", dut_x(0), 0);
            run_frame(0, 0, 0, 0);
            check($sformatf("vec%0d x", v), dut_x(vecs[v].chk), vecs[v].ex);
            check($sformatf("vec%0d ctrl", v), dut_c(vecs[v].chk), vecs[v].ec);
        end

        // Right wrap on lane 0; lane 1 disabled.
        do_write(0, 630);
        do_write(5, 50);
        do_write(32, lane_word(1, 0, 0, 12));
        run_frame(0, 0, 0, 0);
        check("right_wrap log0", dut_x(0), 2);
        check("disabled log5", dut_x(5), 50);

        // Left wrap on lane 1, two frames.
        do_write(7, 3);
        do_write(33, lane_word(1, 1, 0, 5));
        run_frame(0, 0, 0, 0);
        check("left_wrap1 log7", dut_x(7), 638);
        run_frame(0, 0, 0, 0);
        check("left_wrap2 log7", dut_x(7), 633);

        // Period 2 on lane 2: prime fcnt with step 0, then six frames with step 4.
        do_write(34, lane_word(1, 0, 2, 0));
        run_frame(0, 0, 0, 0);
        run_frame(0, 0, 0, 0);
        do_write(34, lane_word(1, 0, 2, 4));
        do_write(10, 100);
        pv = '{104, 104, 104, 108, 108, 108};
        for (int t = 0; t < 6; t++) begin
            run_frame(0, 0, 0, 0);
            check($sformatf("period tick%0d log10", t + 1), dut_x(10), pv[t]);
        end

        // Collision: CPU writes log 4 exactly at E5 while lane 0 moves by 8.
        do_write(32, lane_word(1, 0, 0, 8));
        do_write(3, 200);
        do_write(4, 100);
        run_frame(5, 4, 300, 0);
        check("collision log4", dut_x(4), 300);
        check("collision log3", dut_x(3), 208);

        // Overrun: extra tick at E10 is ignored, then cleared.
        run_frame(0, 0, 0, 10);
        check("overrun set", int'(overrun), 1);
        do_write(63, 0);
        check("overrun cleared", int'(overrun), 0);
        // Clear in the same cycle as a new overrun event leaves it set.
        run_frame(21, 63, 0, 21);
        check("overrun clr_vs_set", int'(overrun), 1);
        do_write(63, 0);
        check("overrun cleared2", int'(overrun), 0);

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            int nw, a, d, we, wa, wd, te;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                a = $urandom_range(0, 9);
                a = (a < 6) ? $urandom_range(0, 19) : (a < 9) ? 32 + $urandom_range(0, 3) : $urandom_range(0, 63);
                d = (a < NL) ? (($urandom_range(0, 31) << 11) | $urandom_range(0, 700)) : $urandom_range(0, 65535);
                do_write(a, d);
            end
            we = $urandom_range(0, 21);
            wa = ($urandom_range(0, 3) == 0) ? 32 + $urandom_range(0, 3) : $urandom_range(0, 19);
            wd = (wa < NL) ? $urandom_range(0, 700) | ($urandom_range(0, 15) << 11) : $urandom_range(0, 1023);
            te = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 21) : 0;
            run_frame(we, wa, wd, te);
            if (m_ovr == 1 && $urandom_range(0, 1) == 1) do_write(63, 0);
        end

        // Reset asserted mid-UPDATE (with an overrun pending) aborts everything.
        frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        repeat (5) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        check("overrun pre_reset", int'(overrun), 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #2;
        m_reset();
        $display("reset asserted mid-UPDATE");
        check_all("midreset");
        for (int i = 15; i < 20; i++)
            check($sformatf("reset log_y[%0d]", i), int'(log_y[11*i +: 11]), 192);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        check_all("post_reset");
        run_frame(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
